cpu_mem_unit: RTL

Memory responder on the far side of the single-cycle CPU's fetch and load/store interface. It holds a 256×16 instruction memory, read at `PC` to drive `IR`, and a 256×8 data memory, read at `Address_out` and written from `Data_out` when `MW` is set. A byte-serial loader with a valid/ready handshake fills instruction memory. The block holds the CPU in reset (`cpu_reset`) until a program load completes.

---
 rtl/cpu_mem_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/cpu_mem_unit.sv
// cpu_mem_unit: instruction/data memory responder for the single-cycle CPU.
// Holds a 256x16 instruction memory (filled by a byte-serial loader) and a
// 256x8 data memory, and keeps the CPU in reset until a program load completes.
module cpu_mem_unit #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  PC,
  output logic [15:0] IR,
  input  logic [7:0]  Address_out,
  input  logic [7:0]  Data_out,
  input  logic        MW,
  output logic [7:0]  Data_in,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_reset,
  output logic [8:0]  ld_count,
  output logic        ld_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD_HI = 2'd1;
  localparam logic [1:0] LOAD_LO = 2'd2;
  localparam logic [1:0] RUN     = 2'd3;

  localparam logic [8:0] COUNT_MAX = 9'd256;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [7:0]  wr_ptr;
  logic [7:0]  hi_byte;
  logic        accept;
  logic        hi_accept;
  logic        imem_we;
  logic        dmem_we;

  logic [15:0] imem [IMEM_DEPTH];
  logic [7:0]  dmem [DMEM_DEPTH];

  // ld_ready depends on state only, so the loader never sees a combinational
  // path from ld_valid back to ld_ready.
  assign ld_ready  = (state == LOAD_HI) || (state == LOAD_LO);
  assign accept    = ld_valid && ld_ready;
  // ld_start wins over any byte presented on the same edge; that byte is dropped.
  assign hi_accept = accept && !ld_start && (state == LOAD_HI);
  assign imem_we   = accept && !ld_start && (state == LOAD_LO);
  assign dmem_we   = MW && (state == RUN);

  // Next-state selection for the load/run sequencer.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt; without it
    // the tool infers a latch for the branches that do not assign.
    state_nxt = state;
    if (ld_start) begin
      state_nxt = LOAD_HI;
    end else begin
      case (state)
        LOAD_HI: if (ld_valid) state_nxt = ld_last ? IDLE : LOAD_LO;
        LOAD_LO: if (ld_valid) state_nxt = ld_last ? RUN  : LOAD_HI;
        default: state_nxt = state;
      endcase
    end
  end

  // Control state: sequencer, CPU reset, write pointer, word count and error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state     <= IDLE;
      cpu_reset <= 1'b1;
      wr_ptr    <= 8'd0;
      hi_byte   <= 8'd0;
      ld_count  <= 9'd0;
      ld_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Registered so it falls exactly on the edge that enters RUN.
      cpu_reset <= (state_nxt != RUN);
      if (ld_start) begin
        wr_ptr   <= 8'd0;
        ld_count <= 9'd0;
        ld_err   <= 1'b0;
      end else if (hi_accept) begin
        hi_byte <= ld_byte;
        // A session ending on a high byte has an odd byte count.
        if (ld_last) ld_err <= 1'b1;
      end else if (imem_we) begin
        wr_ptr <= wr_ptr + 8'd1;
        // A word beyond 256 has wrapped over address 0.
        if (ld_count == COUNT_MAX) ld_err <= 1'b1;
        else                       ld_count <= ld_count + 9'd1;
      end
    end
  end

  // Instruction memory write port, fed by the loader.
  always_ff @(posedge clk) begin
    // NOTE: memory arrays carry no reset; contents survive reset and a partial
    // load leaves already-written words in place.
    if (imem_we) imem[wr_ptr] <= {hi_byte, ld_byte};
  end

  // Data memory write port, live only while the CPU runs.
  always_ff @(posedge clk) begin
    if (dmem_we) dmem[Address_out] <= Data_out;
  end

  // Zero-latency reads; IR is a no-op (MOVA R0,R0) while the CPU is held.
  assign IR      = (state == RUN) ? imem[PC] : 16'h0000;
  assign Data_in = dmem[Address_out];

endmodule
